// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// The parity state is always declared; it is only reachable when SERIAL_TX_PARITY_EN is defined.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of each bit.
// A synchronous clear re-aligns the count when a new frame is accepted.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_end = enable && (count == LAST);

    // Wrap explicitly at LAST so non-power-of-two periods never overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to compile in the even-parity bit.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    tx_state_t         state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n, shifted;
    logic [IW-1:0]     idx, idx_n;
    logic              serial_n;
    logic              done_n;
    logic              accept;
    logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity, parity_n;
`endif

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign shifted  = shreg >> 1;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (tx_busy),
        .bit_end(bit_end)
    );

    // The line value is computed one cycle ahead so tx_serial can be a plain register.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        idx_n    = idx;
        serial_n = tx_serial;
        done_n   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_n = parity;
`endif
        case (state)
            IDLE: begin
                serial_n = IDLE_LEVEL;
                if (accept) begin
                    state_n  = START;
                    shreg_n  = tx_data;
                    idx_n    = '0;
                    serial_n = START_BIT;
`ifdef SERIAL_TX_PARITY_EN
                    parity_n = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    serial_n = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_n  = PARITY;
                        serial_n = parity;
`else
                        state_n  = STOP;
                        serial_n = STOP_BIT;
`endif
                    end else begin
                        idx_n    = idx + 1'b1;
                        shreg_n  = shifted;
                        serial_n = shifted[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n  = STOP;
                    serial_n = STOP_BIT;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n  = IDLE;
                    serial_n = IDLE_LEVEL;
                    done_n   = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            tx_serial <= IDLE_LEVEL;
            tx_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            idx       <= idx_n;
            tx_serial <= serial_n;
            tx_done   <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            parity    <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Honours SERIAL_TX_PARITY_EN so the same bench covers both builds.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef struct {
        logic [17:0] bits;
        int          nbits;
        logic [7:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       ready0, ser0, busy0, done0;
    logic       ready1, ser1, busy1, done1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [63:0] cap0, cap1;
    int          n0 = 0, n1 = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
    );

    // Frame bits in transmit order (bit 0 goes out first); parity is supplied hand-computed.
    function automatic exp_t mkFrame(input logic [7:0] d, input logic p);
        exp_t e;
        e.data  = d;
        e.nbits = FRAME_BITS;
`ifdef SERIAL_TX_PARITY_EN
        e.bits  = {7'b0, 1'b1, p, d, 1'b0};
`else
        e.bits  = {8'b0, 1'b1, d, 1'b0};
        if (p) e.bits[17] = 1'b0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic scoreFrame(input int which, input int cpb, input logic [63:0] cap, input int n);
        exp_t e;
        int   bad;
        checks++;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            errors++;
            $display("[TB] FAIL unexpected_frame dut%0d: got tx_done with %0d cycles, expected no frame", which, n);
            return;
        end
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput($sformatf("frame_len dut%0d data %02h", which, e.data), n, e.nbits * cpb);
        bad = -1;
        for (int i = 0; i < n && i < 64; i++) begin
            if (bad < 0 && cap[i] !== e.bits[i / cpb]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL frame_bits dut%0d data %02h: cycle %0d got %b expected %b",
                     which, e.data, bad, cap[bad], e.bits[bad / cpb]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done0 === 1'b1) begin
            checkOutput("busy_at_done dut0", busy0, 0);
            scoreFrame(0, 4, cap0, n0);
            n0 = 0;
        end else if (busy0 === 1'b1) begin
            if (n0 < 64) cap0[n0] = ser0;
            n0++;
        end
        if (rst) n0 = 0;
    end

    always @(posedge clk) begin
        #1;
        if (done1 === 1'b1) begin
            checkOutput("busy_at_done dut1", busy1, 0);
            scoreFrame(1, 1, cap1, n1);
            n1 = 0;
        end else if (busy1 === 1'b1) begin
            if (n1 < 64) cap1[n1] = ser1;
            n1++;
        end
        if (rst) n1 = 0;
    end

    task automatic applyStimulus(input int which, input logic [7:0] d, input logic p);
        @(negedge clk);
        if (which == 0) begin
            q0.push_back(mkFrame(d, p));
            data0 = d; valid0 = 1'b1;
        end else begin
            q1.push_back(mkFrame(d, p));
            data1 = d; valid1 = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("accept_serial", (which == 0) ? ser0 : ser1, 0);
        checkOutput("accept_busy", (which == 0) ? busy0 : busy1, 1);
        checkOutput("accept_ready", (which == 0) ? ready0 : ready1, 0);
        @(negedge clk);
        if (which == 0) begin valid0 = 1'b0; data0 = ~d; end
        else begin valid1 = 1'b0; data1 = ~d; end
    endtask

    task automatic waitDone(input int which, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((which == 0 && done0) || (which == 1 && done1)) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout dut%0d: got no tx_done within %0d cycles, expected a pulse", which, budget);
    endtask

    initial begin
        int rdy_cnt;
        int done_cnt;
        int busy_cnt;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_serial", ser0, 1);
        checkOutput("reset_ready", ready0, 1);
        checkOutput("reset_busy", busy0, 0);
        checkOutput("reset_done", done0, 0);
        checkOutput("reset_serial dut1", ser1, 1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single frames");
        applyStimulus(0, 8'hA5, 1'b0);
        waitDone(0, 100);
        applyStimulus(0, 8'h07, 1'b1);
        waitDone(0, 100);

        $display("[TB] back-to-back");
        @(negedge clk);
        q0.push_back(mkFrame(8'h00, 1'b0));
        q0.push_back(mkFrame(8'hFF, 1'b0));
        data0 = 8'h00; valid0 = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b_accept", ser0, 0);
        rdy_cnt = ready0 ? 1 : 0;
        @(negedge clk);
        data0 = 8'hFF;
        for (int k = 1; k <= FRAME_BITS * 4; k++) begin
            @(posedge clk); #1;
            if (ready0) rdy_cnt++;
            if (k == FRAME_BITS * 4) checkOutput("b2b_done_cycle", done0, 1);
        end
        @(posedge clk); #1;
        checkOutput("b2b_no_gap_serial", ser0, 0);
        checkOutput("b2b_no_gap_busy", busy0, 1);
        checkOutput("b2b_ready_once", rdy_cnt, 1);
        @(negedge clk);
        valid0 = 1'b0;
        waitDone(0, 100);

        $display("[TB] valid ignored while busy");
        applyStimulus(0, 8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        data0 = 8'h55; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0; data0 = 8'h00;
        waitDone(0, 100);
        busy_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (busy0) busy_cnt++;
        end
        checkOutput("ignore_no_extra_frame", busy_cnt, 0);

        $display("[TB] reset mid-frame");
        @(negedge clk);
        data0 = 8'hF0; valid0 = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_accept_busy", busy0, 1);
        @(negedge clk);
        valid0 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_serial", ser0, 1);
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_ready", ready0, 1);
        checkOutput("abort_done", done0, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done0) done_cnt++;
        end
        checkOutput("abort_no_done", done_cnt, 0);
        applyStimulus(0, 8'h81, 1'b0);
        waitDone(0, 100);

        $display("[TB] one clock per bit");
        applyStimulus(1, 8'h3C, 1'b0);
        waitDone(1, 40);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty dut0", q0.size(), 0);
        checkOutput("scoreboard_empty dut1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that serialises a parallel byte onto a single wire, one bit period per `CLKS_PER_BIT` clocks. It is the sending end of the single-bit data line that the team's D-flip-flop capture stage samples. It sits between a parallel byte source, via a valid/ready handshake, and the `uo_out[0]` serial pin. Frame format:

- idle-high line;
- one start bit (0);
- `DATA_W` data bits, LSB first;
- optional even-parity bit;
- one stop bit (1).

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame. Legal range is 1 to 16.
- `CLKS_PER_BIT`, default 4: clocks per serial bit. Must be ≥1; 1 is legal.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `tx_data`  in  `DATA_W`: byte to send. Sampled only on acceptance.
- `tx_valid`  in  1: source has data.
- `tx_ready`  out  1: block can accept. High only in IDLE.
- `tx_serial`  out  1: serial line. Registered, glitch-free.
- `tx_busy`  out  1: a frame is in progress (any state other than IDLE).
- `tx_done`  out  1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_serial`=1, `tx_ready`=1.
  - Acceptance occurs on a rising edge where `tx_valid && tx_ready`.
  - On acceptance: latch `tx_data` into the shift register, clear the bit-index and clock counters, go to START.
- START: drive 0 for `CLKS_PER_BIT` clocks, then go to DATA.
- DATA:
  - Drive shift-register bit 0. Shift right once per bit period.
  - After `DATA_W` bits, go to PARITY if enabled, else go to STOP.
- PARITY: drive the XOR of the latched data for one bit period, then go to STOP.
- STOP: drive 1 for one bit period, then go to IDLE and assert `tx_done` for exactly one cycle.
- `tx_valid` while busy is ignored. Neither the data nor the frame is disturbed.
- `tx_data` changes after acceptance have no effect.
- Back-to-back: `tx_ready` is high in the same cycle `tx_done` pulses. Acceptance in that cycle starts the next start bit with no idle bit between frames.
- Reset values: `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0.
- Reset mid-frame: the frame is aborted at the next edge and the line returns high. No `tx_done` pulse is generated.
- Reset has priority over acceptance in the same cycle.

## Timing
- Acceptance at edge k: `tx_serial` goes to 0 after edge k. `tx_busy`=1 and `tx_ready`=0 from that point.
- Every bit is held exactly `CLKS_PER_BIT` cycles. There is no jitter and no short first bit.
- Frame length is (2+`DATA_W`+P)×`CLKS_PER_BIT` cycles, where P=1 with parity and 0 without.
- `tx_done` is high in the first cycle after the stop bit ends. `tx_busy` is 0 in that same cycle.
- The clock counter width is $clog2(`CLKS_PER_BIT`), minimum 1 bit. It counts 0 to `CLKS_PER_BIT`-1 and wraps with no overflow path.
- The bit index counts 0 to `DATA_W`-1.

## Configuration
- Macro: `SERIAL_TX_PARITY_EN`.
- Defined: the PARITY state and parity bit are compiled in, using even parity. The frame is 1 bit longer.
- Undefined: the PARITY state and its logic are absent. DATA goes directly to STOP.

## Structure
- Package `serial_tx_pkg` holds:
  - the FSM state enum;
  - constants `START_BIT`=0, `STOP_BIT`=1, `IDLE_LEVEL`=1.
- Sub-module `serial_bit_timer`:
  - a `CLKS_PER_BIT` counter with synchronous clear;
  - outputs a one-cycle `bit_end` pulse;
  - used by all non-IDLE states.
- The top level holds the FSM, shift register, bit index and output registers.

## Test plan
- Single frame: `CLKS_PER_BIT`=4, no parity, send 0xA5. The line must carry 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles (40 cycles total). `tx_done` pulses at cycle 40 after acceptance.
- Parity: `SERIAL_TX_PARITY_EN` defined, send 0xA5 then 0x07. Parity bit is 0 for 0xA5 and 1 for 0x07. Each frame is 44 cycles.
- Back-to-back: hold `tx_valid` high with 0x00 then 0xFF. The 0xFF start bit begins in the cycle after the 0x00 stop bit ends, with no idle gap. `tx_ready` is high exactly one cycle per frame.
- Busy/ignore: pulse `tx_valid` with 0x55 mid-frame while sending 0x3C. The transmitted data must remain 0x3C, and 0x55 is never sent.
- Reset mid-frame: assert `rst` at cycle 13 of an 0xF0 frame. The next edge gives `tx_serial`=1, `tx_busy`=0, `tx_ready`=1, and there is no `tx_done` pulse. A fresh 0x81 frame afterwards is correct.
- Minimum bit period: `CLKS_PER_BIT`=1, send 0x3C. Bits change every cycle: 0,0,0,1,1,1,1,0,0,1 (10 cycles).
